// File: rtl/demux_1to4.sv
// Registered 1-to-4 demultiplexer: steers `in` to the lane picked by `sel`,
// zeroes the other lanes, and flags the active lane with a one-hot strobe.
module demux_1to4 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] in,
   input  logic [1:0]       sel,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic [3:0]       out_valid
);

   localparam int unsigned LANES = 4;

   logic [WIDTH-1:0] lane_d [LANES];
   logic [3:0]       valid_d;

   // Next-lane decode; disabled cycles and unknown selects clear everything
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         lane_d[i] = '0;
      end
      valid_d = 4'b0000;
      if (en) begin
         case (sel)
            2'd0: begin lane_d[0] = in; valid_d = 4'b0001; end
            2'd1: begin lane_d[1] = in; valid_d = 4'b0010; end
            2'd2: begin lane_d[2] = in; valid_d = 4'b0100; end
            2'd3: begin lane_d[3] = in; valid_d = 4'b1000; end
            default: begin
               for (int i = 0; i < LANES; i++) begin
                  lane_d[i] = '0;
               end
               valid_d = 4'b0000;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out0      <= '0;
         out1      <= '0;
         out2      <= '0;
         out3      <= '0;
         out_valid <= 4'b0000;
      end else begin
         out0      <= lane_d[0];
         out1      <= lane_d[1];
         out2      <= lane_d[2];
         out3      <= lane_d[3];
         out_valid <= valid_d;
      end
   end

endmodule

// File: tb/tb_demux_1to4.sv
// Directed and randomized checks of demux_1to4 at WIDTH=1 and WIDTH=8.
module tb_demux_1to4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic [1:0] sel = 2'd0;
   logic       in1 = 1'b0;
   logic [7:0] in8 = 8'h00;

   logic       a0, a1, a2, a3;
   logic [3:0] valid1;
   logic [7:0] b0, b1, b2, b3;
   logic [3:0] valid8;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   demux_1to4 #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .in(in1), .sel(sel),
      .out0(a0), .out1(a1), .out2(a2), .out3(a3), .out_valid(valid1)
   );

   demux_1to4 #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .en(en), .in(in8), .sel(sel),
      .out0(b0), .out1(b1), .out2(b2), .out3(b3), .out_valid(valid8)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] sweep_exp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

   logic       r_en;
   logic [1:0] r_sel;
   logic       r_in1;
   logic [7:0] r_in8;
   logic [3:0] e_valid;
   logic [3:0] e_lanes1;
   logic [31:0] e_lanes8;

   initial begin
      // First capture, then asynchronous reset between edges
      en = 1'b1; in1 = 1'b1; sel = 2'd2; in8 = 8'h3C;
      tick();
      check("pre_rst_lanes1", 64'({a3, a2, a1, a0}), 64'(4'b0100));
      check("pre_rst_valid1", 64'(valid1), 64'(4'b0100));
      #2 rst = 1'b1;
      #1;
      check("rst_async_lanes1", 64'({a3, a2, a1, a0}), 64'(4'b0000));
      check("rst_async_valid1", 64'(valid1), 64'(4'b0000));
      check("rst_async_lanes8", 64'({b3, b2, b1, b0}), 64'(32'h0));
      check("rst_async_valid8", 64'(valid8), 64'(4'b0000));
      tick();
      check("rst_held_lanes1", 64'({a3, a2, a1, a0}), 64'(4'b0000));
      check("rst_held_valid8", 64'(valid8), 64'(4'b0000));

      // Lane sweep at WIDTH=1
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         sel = 2'(k);
         tick();
         check($sformatf("sweep_lanes1_%0d", k), 64'({a3, a2, a1, a0}), 64'(sweep_exp[k]));
         check($sformatf("sweep_valid1_%0d", k), 64'(valid1), 64'(sweep_exp[k]));
      end

      // Zero data still asserts valid; then a full byte on lane 3
      in8 = 8'h00; sel = 2'd1;
      tick();
      check("zero_lanes8", 64'({b3, b2, b1, b0}), 64'(32'h0000_0000));
      check("zero_valid8", 64'(valid8), 64'(4'b0010));
      in8 = 8'hA5; sel = 2'd3;
      tick();
      check("a5_lanes8", 64'({b3, b2, b1, b0}), 64'(32'hA500_0000));
      check("a5_valid8", 64'(valid8), 64'(4'b1000));

      // Enable low clears rather than holds
      en = 1'b1; in1 = 1'b1; sel = 2'd2; in8 = 8'h7E;
      tick();
      check("en_hi_lanes1", 64'({a3, a2, a1, a0}), 64'(4'b0100));
      check("en_hi_lanes8", 64'({b3, b2, b1, b0}), 64'(32'h007E_0000));
      en = 1'b0;
      tick();
      check("en_lo_lanes1", 64'({a3, a2, a1, a0}), 64'(4'b0000));
      check("en_lo_valid1", 64'(valid1), 64'(4'b0000));
      check("en_lo_lanes8", 64'({b3, b2, b1, b0}), 64'(32'h0));
      check("en_lo_valid8", 64'(valid8), 64'(4'b0000));

      // Reset mid-stream, then release and capture on lane 3
      en = 1'b1; in1 = 1'b1; in8 = 8'h11; sel = 2'd0;
      tick();
      sel = 2'd1;
      tick();
      check("stream_lanes1", 64'({a3, a2, a1, a0}), 64'(4'b0010));
      sel = 2'd2;
      #3 rst = 1'b1;
      #1;
      check("mid_rst_lanes1", 64'({a3, a2, a1, a0}), 64'(4'b0000));
      check("mid_rst_valid1", 64'(valid1), 64'(4'b0000));
      check("mid_rst_lanes8", 64'({b3, b2, b1, b0}), 64'(32'h0));
      #1 rst = 1'b0;
      sel = 2'd3;
      tick();
      check("post_rst_lanes1", 64'({a3, a2, a1, a0}), 64'(4'b1000));
      check("post_rst_valid1", 64'(valid1), 64'(4'b1000));
      check("post_rst_lanes8", 64'({b3, b2, b1, b0}), 64'(32'h1100_0000));

      // Randomized traffic: exact result plus zero-or-one-hot strobe
      for (int n = 0; n < 1000; n++) begin
         r_en  = 1'($urandom_range(0, 3) != 0);
         r_sel = 2'($urandom_range(0, 3));
         r_in1 = 1'($urandom_range(0, 1));
         r_in8 = 8'($urandom_range(0, 255));
         en = r_en; sel = r_sel; in1 = r_in1; in8 = r_in8;
         tick();
         e_valid  = r_en ? (4'b0001 << r_sel) : 4'b0000;
         e_lanes1 = r_en ? (4'(r_in1) << r_sel) : 4'b0000;
         e_lanes8 = r_en ? (32'(r_in8) << (8 * int'(r_sel))) : 32'h0;
         check("rand_valid8", 64'(valid8), 64'(e_valid));
         check("rand_lanes8", 64'({b3, b2, b1, b0}), 64'(e_lanes8));
         check("rand_lanes1", 64'({a3, a2, a1, a0}), 64'(e_lanes1));
         check("rand_onehot0", 64'($onehot0(valid1)), 64'(1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/demux_1to4.md
Name: demux_1to4

Overview:
Registered 1-to-4 demultiplexer. A data word on `in` is steered to exactly one of four outputs chosen by the 2-bit `sel`; the three unselected outputs are driven to zero. Outputs are registered, giving one clock of latency. A per-output valid strobe tells downstream consumers which lane carries data. Used as a generic lane/route selector in datapaths.

Parameters:
WIDTH, 1, bit width of `in` and of each data output.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous reset, active-high
en  input  1  enable; when high, the current `in`/`sel` are captured at the next rising `clk` edge
in  input  WIDTH  data to route
sel  input  2  lane select: 0→out0, 1→out1, 2→out2, 3→out3
out0  output  WIDTH  lane 0 data
out1  output  WIDTH  lane 1 data
out2  output  WIDTH  lane 2 data
out3  output  WIDTH  lane 3 data
out_valid  output  4  one-hot lane strobe; bit k corresponds to out<k>

Behaviour:
- Reset: while `rst`=1, regardless of `clk`:
  - out0..out3 = 0
  - out_valid = 4'b0000
- Reset assertion takes effect immediately (asynchronous). Release is sampled at the next rising `clk`; the first capture can occur on the first rising edge with `rst`=0.
- On each rising `clk` edge with `rst`=0 and `en`=1:
  - out<sel> ← in
  - all other outputs ← 0
  - out_valid ← one-hot of `sel` (sel=0 → 0001, 1 → 0010, 2 → 0100, 3 → 1000)
- On each rising `clk` edge with `rst`=0 and `en`=0:
  - out0..out3 ← 0
  - out_valid ← 0000
  - Outputs are cleared, not held.
- Latency: exactly one clock from `en`/`in`/`sel` sampling to outputs. No combinational path from any input to any output.
- Throughput: a new word is accepted every cycle. Consecutive cycles with different `sel` values move data between lanes cycle by cycle. There is no bubble or stall.
- Invariant: at most one bit of `out_valid` is set at any time. Every output whose valid bit is 0 reads all-zero.
- A routed `in` of 0 still asserts the corresponding `out_valid` bit. Valid reflects selection, not data content.
- Invalid `sel` (X/Z in simulation): the `case` default clears all outputs and `out_valid`. There is no latch inference.
- Reset mid-stream: all outputs clear immediately, regardless of pending `en`/`sel`. The prior routing is not retained after release.
- Width rule: data passes unmodified. There is no extension or truncation, and all lanes are exactly WIDTH bits.

Test Plan:
- Reset: assert `rst`=1 with `en`=1, `in`=1, `sel`=2 → out3..out0 = 0000 and out_valid = 0000 immediately, without waiting for a clock edge.
- Lane sweep (WIDTH=1): release reset, `en`=1, `in`=1, `sel`=0,1,2,3 on successive cycles → out3..out0 one cycle later = 0001, 0010, 0100, 1000; out_valid matches each value.
- Zero data (WIDTH=8): `in`=8'h00, `sel`=1, `en`=1 → out1 = 00 and out_valid = 0010. Then `in`=8'hA5, `sel`=3 → out3 = A5, out0..out2 = 00, out_valid = 1000.
- Enable low: `en`=1, `in`=1, `sel`=2, then `en`=0 → out2 = 1 for one cycle, then all outputs 0 and out_valid = 0000 on the next edge.
- Reset mid-stream: while streaming `in`=1 with `sel` incrementing, assert `rst` asynchronously between edges → all outputs 0 at once. After release, the first edge with `en`=1, `sel`=3 → out3 = 1 only.
- Invariant check: random `in`/`sel`/`en` for 1000 cycles → `out_valid` is always zero or one-hot, and every unselected lane reads zero.
